// File: rtl/theta_eps_search.sv
// Final decision stage of the CP-based timing/frequency estimator: tracks the argmax of
// lambda over a SYM_LEN-sample window and emits theta, eps = -ang/(2*pi) and the winning lambda.
module theta_eps_search #(
    parameter int SYM_LEN  = 256,
    parameter int INV2PI_K = 10430,
    parameter int LAMBDA_W = 14,
    parameter int ANG_W    = 11,
    parameter int EPS_W    = 21
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic                       in_sof,
    input  logic signed [LAMBDA_W-1:0] in_lambda,
    input  logic signed [ANG_W-1:0]    in_ang,
    output logic                       out_valid,
    output logic        [7:0]          out_theta,
    output logic signed [EPS_W-1:0]    out_eps,
    output logic signed [LAMBDA_W-1:0] out_lambda_max
);

    // Handshake: a sample is consumed on every clock where in_valid is high; there is no
    // ready in either direction, and out_valid is a one-cycle pulse the consumer must take.

    localparam int                P_W      = 26;
    localparam logic [7:0]        LAST_IDX = 8'(SYM_LEN - 1);
    localparam logic signed [P_W-1:0] K_S      = P_W'(INV2PI_K);
    localparam logic signed [P_W-1:0] RND_HALF = 26'sd8;

    logic        [7:0]          idx;
    logic        [7:0]          k;
    logic        [7:0]          idx_next;
    logic signed [LAMBDA_W-1:0] max_lambda;
    logic        [7:0]          max_idx;
    logic signed [ANG_W-1:0]    max_ang;

    logic                       take;
    logic                       win_end;
    logic signed [LAMBDA_W-1:0] cand_lambda;
    logic        [7:0]          cand_idx;
    logic signed [ANG_W-1:0]    cand_ang;

    logic signed [P_W-1:0]      ang_ext;
    logic signed [P_W-1:0]      prod;
    logic signed [P_W-1:0]      rnd;
    logic signed [EPS_W-1:0]    eps_val;

    // Index of the current sample, and the running max including this sample.
    always_comb begin
        k           = in_sof ? 8'd0 : idx;
        idx_next    = (k == LAST_IDX) ? 8'd0 : k + 8'd1;
        win_end     = in_valid && (k == LAST_IDX);
        // Strict greater-than keeps the earliest index on ties.
        take        = (k == 8'd0) || (in_lambda > max_lambda);
        cand_lambda = max_lambda;
        cand_idx    = max_idx;
        cand_ang    = max_ang;
        if (take) begin
            cand_lambda = in_lambda;
            cand_idx    = k;
            cand_ang    = in_ang;
        end
    end

    // eps = -floor((ang * K + 8) / 16); |ang| <= 1024 keeps the result inside EPS_W bits.
    always_comb begin
        ang_ext = P_W'(cand_ang);
        prod    = ang_ext * K_S;
        rnd     = (prod + RND_HALF) >>> 4;
        eps_val = EPS_W'(-rnd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            max_lambda <= '0;
            max_idx    <= '0;
            max_ang    <= '0;
        end else if (in_valid) begin
            idx        <= idx_next;
            max_lambda <= cand_lambda;
            max_idx    <= cand_idx;
            max_ang    <= cand_ang;
        end
    end

    // Result registers capture the closing sample's view while the max registers
    // are free to reload for a back-to-back window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_theta      <= '0;
            out_eps        <= '0;
            out_lambda_max <= '0;
        end else begin
            out_valid <= win_end;
            if (win_end) begin
                out_theta      <= cand_idx;
                out_eps        <= eps_val;
                out_lambda_max <= cand_lambda;
            end
        end
    end

endmodule
